// File: rtl/imem_loader.sv
// imem_loader: program loader on the writer side of the instruction-memory
// fetch path. Accepts a byte stream over valid/ready, packs big-endian 32-bit
// words and writes them to consecutive word indices starting at BASE_ADDR,
// holding the CPU in reset while the load is in progress.
// Optional build macro LOADER_CHECKSUM_EN adds a running 32-bit sum of the
// words written in the current load on output checksum.
module imem_loader #(
    parameter int unsigned  DEPTH     = 4096,
    parameter int unsigned  IDX_W     = 12,
    parameter logic [31:0]  BASE_ADDR = 32'h00003000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic             wr_en,
    output logic [IDX_W-1:0] wr_index,
    output logic [31:0]      wr_addr,
    output logic [31:0]      wr_data,
    output logic             cpu_hold,
    output logic             done,
    output logic             full,
    output logic             partial,
`ifdef LOADER_CHECKSUM_EN
    output logic [31:0]      checksum,
`endif
    output logic [IDX_W:0]   words_loaded
);

    typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    state_t           state, state_nxt;
    logic [2:0]       byte_cnt;
    logic [IDX_W-1:0] word_idx;
    // Only the three most recent bytes are kept; the fourth comes straight
    // from in_data when the word is assembled.
    logic [23:0]      shift;
    logic             last_seen;
    logic             fire;
    logic [31:0]      word_nxt;
    logic             in_ready_d, wr_en_d, cpu_hold_d, done_d;

    assign fire    = in_valid && in_ready;
    assign wr_addr = BASE_ADDR + (32'(wr_index) << 2);

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, next-cycle output strobes and the zero-padded word image.
    always_comb begin
        state_nxt  = state;
        word_nxt   = '0;
        in_ready_d = 1'b0;
        wr_en_d    = 1'b0;
        cpu_hold_d = 1'b0;
        done_d     = 1'b0;

        case (byte_cnt)
            3'd0:    word_nxt = {in_data, 24'h000000};
            3'd1:    word_nxt = {shift[7:0], in_data, 16'h0000};
            3'd2:    word_nxt = {shift[15:0], in_data, 8'h00};
            default: word_nxt = {shift[23:0], in_data};
        endcase

        case (state)
            IDLE, DONE: begin
                if (start) state_nxt = RECV;
            end
            RECV: begin
                if (fire && (byte_cnt == 3'd3 || in_last)) state_nxt = WRITE;
            end
            WRITE: begin
                if (last_seen || word_idx == LAST_IDX) state_nxt = DONE;
                else                                    state_nxt = RECV;
            end
            default: state_nxt = IDLE;
        endcase

        in_ready_d = (state_nxt == RECV);
        wr_en_d    = (state_nxt == WRITE);
        cpu_hold_d = (state_nxt == RECV) || (state_nxt == WRITE);
        done_d     = (state_nxt == DONE);
    end

    // Datapath, counters and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            in_ready     <= 1'b0;
            wr_en        <= 1'b0;
            wr_index     <= '0;
            wr_data      <= '0;
            cpu_hold     <= 1'b0;
            done         <= 1'b0;
            full         <= 1'b0;
            partial      <= 1'b0;
            words_loaded <= '0;
            byte_cnt     <= '0;
            word_idx     <= '0;
            shift        <= '0;
            last_seen    <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            checksum     <= '0;
`endif
        end else begin
            in_ready <= in_ready_d;
            wr_en    <= wr_en_d;
            cpu_hold <= cpu_hold_d;
            done     <= done_d;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        byte_cnt     <= '0;
                        word_idx     <= '0;
                        shift        <= '0;
                        last_seen    <= 1'b0;
                        words_loaded <= '0;
                        full         <= 1'b0;
                        partial      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
                        checksum     <= '0;
`endif
                    end
                end
                RECV: begin
                    if (fire) begin
                        shift    <= {shift[15:0], in_data};
                        byte_cnt <= byte_cnt + 3'd1;
                        if (in_last) begin
                            last_seen <= 1'b1;
                            if (byte_cnt != 3'd3) partial <= 1'b1;
                        end
                        if (byte_cnt == 3'd3 || in_last) begin
                            wr_index <= word_idx;
                            wr_data  <= word_nxt;
                        end
                    end
                end
                WRITE: begin
                    byte_cnt     <= '0;
                    words_loaded <= words_loaded + (IDX_W+1)'(1);
                    if (word_idx != LAST_IDX) word_idx <= word_idx + IDX_W'(1);
                    if (!last_seen && word_idx == LAST_IDX) full <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
                    checksum     <= checksum + wr_data;
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed self-checking bench for imem_loader. Instance u0
// uses default sizing; u1 uses DEPTH=4 to reach the full condition quickly.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        reset;

    logic        start, in_valid, in_last, in_ready;
    logic [7:0]  in_data;
    logic        wr_en, cpu_hold, done, full, partial;
    logic [11:0] wr_index;
    logic [31:0] wr_addr, wr_data;
    logic [12:0] words_loaded;

    logic        start1, in_valid1, in_last1, in_ready1;
    logic [7:0]  in_data1;
    logic        wr_en1, cpu_hold1, done1, full1, partial1;
    logic [1:0]  wr_index1;
    logic [31:0] wr_addr1, wr_data1;
    logic [2:0]  words_loaded1;

`ifdef LOADER_CHECKSUM_EN
    logic [31:0] checksum, checksum1;
`endif

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] wd [0:63];
    logic [31:0] wi [0:63];
    logic [31:0] wa [0:63];
    int          wn = 0;
    int          ready_in_write = 0;
    logic [31:0] wd1 [0:15];
    int          wn1 = 0;
    int          base;

    always #5 clk = ~clk;

    imem_loader u0 (
        .clk(clk), .reset(reset), .start(start), .in_data(in_data),
        .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
        .wr_en(wr_en), .wr_index(wr_index), .wr_addr(wr_addr), .wr_data(wr_data),
        .cpu_hold(cpu_hold), .done(done), .full(full), .partial(partial),
`ifdef LOADER_CHECKSUM_EN
        .checksum(checksum),
`endif
        .words_loaded(words_loaded)
    );

    imem_loader #(.DEPTH(4), .IDX_W(2), .BASE_ADDR(32'h00003000)) u1 (
        .clk(clk), .reset(reset), .start(start1), .in_data(in_data1),
        .in_valid(in_valid1), .in_last(in_last1), .in_ready(in_ready1),
        .wr_en(wr_en1), .wr_index(wr_index1), .wr_addr(wr_addr1), .wr_data(wr_data1),
        .cpu_hold(cpu_hold1), .done(done1), .full(full1), .partial(partial1),
`ifdef LOADER_CHECKSUM_EN
        .checksum(checksum1),
`endif
        .words_loaded(words_loaded1)
    );

    // Write-port monitor: records every write strobe seen on either instance.
    always @(negedge clk) begin
        if (wr_en) begin
            if (wn < 64) begin
                wd[wn] = wr_data;
                wi[wn] = 32'(wr_index);
                wa[wn] = wr_addr;
            end
            wn++;
            if (in_ready) ready_in_write++;
        end
        if (wr_en1) begin
            if (wn1 < 16) wd1[wn1] = wr_data1;
            wn1++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic pulse_start1();
        start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
    endtask

    // Offer one byte on u0 and return #1 after the edge that accepted it.
    task automatic send(input logic [7:0] b, input logic last);
        bit ok;
        ok = 1'b0;
        in_valid = 1'b1;
        in_data  = b;
        in_last  = last;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk); #1;
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("send_timeout", 32'(ok), 32'd1);
    endtask

    task automatic send1(input logic [7:0] b, input logic last);
        bit ok;
        ok = 1'b0;
        in_valid1 = 1'b1;
        in_data1  = b;
        in_last1  = last;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (in_ready1) begin
                @(posedge clk); #1;
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("send1_timeout", 32'(ok), 32'd1);
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) break;
        end
        check(tag, 32'(done), 32'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = 8'h00;
        start1 = 1'b0; in_valid1 = 1'b0; in_last1 = 1'b0; in_data1 = 8'h00;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_wr_en", 32'(wr_en), 32'd0);
        check("rst_cpu_hold", 32'(cpu_hold), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_words", 32'(words_loaded), 32'd0);
        check("rst_wr_addr", wr_addr, 32'h00003000);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;

        // Program load
        base = wn;
        pulse_start();
        check("load_cpu_hold", 32'(cpu_hold), 32'd1);
        send(8'h34, 1'b0); send(8'h02, 1'b0); send(8'h00, 1'b0); send(8'h05, 1'b0);
        check("load_latency_wr_en", 32'(wr_en), 32'd1);
        send(8'h8C, 1'b0); send(8'h01, 1'b0); send(8'h00, 1'b0); send(8'h00, 1'b1);
        in_valid = 1'b0; in_last = 1'b0;
        wait_done("load_done");
        check("load_nwrites", 32'(wn - base), 32'd2);
        check("load_w0_data", wd[base], 32'h34020005);
        check("load_w0_idx", wi[base], 32'd0);
        check("load_w0_addr", wa[base], 32'h00003000);
        check("load_w1_data", wd[base+1], 32'h8C010000);
        check("load_w1_idx", wi[base+1], 32'd1);
        check("load_w1_addr", wa[base+1], 32'h00003004);
        check("load_words", 32'(words_loaded), 32'd2);
        check("load_cpu_hold_rel", 32'(cpu_hold), 32'd0);
        check("load_partial", 32'(partial), 32'd0);
        check("load_full", 32'(full), 32'd0);
`ifdef LOADER_CHECKSUM_EN
        check("load_checksum", checksum, 32'hC0030005);
`endif

        // Partial word
        base = wn;
        pulse_start();
`ifdef LOADER_CHECKSUM_EN
        check("start_clears_checksum", checksum, 32'd0);
`endif
        check("restart_done_clr", 32'(done), 32'd0);
        send(8'hAA, 1'b0); send(8'hBB, 1'b1);
        in_valid = 1'b0; in_last = 1'b0;
        wait_done("part_done");
        check("part_nwrites", 32'(wn - base), 32'd1);
        check("part_w0_data", wd[base], 32'hAABB0000);
        check("part_w0_idx", wi[base], 32'd0);
        check("part_partial", 32'(partial), 32'd1);
        check("part_words", 32'(words_loaded), 32'd1);

        // Backpressure: in_valid stays high across WRITE cycles
        base = wn;
        pulse_start();
        for (int i = 1; i <= 8; i++) send(8'(i), (i == 8));
        in_valid = 1'b0; in_last = 1'b0;
        wait_done("bp_done");
        check("bp_nwrites", 32'(wn - base), 32'd2);
        check("bp_w0_data", wd[base], 32'h01020304);
        check("bp_w1_data", wd[base+1], 32'h05060708);
        check("bp_ready_in_write", 32'(ready_in_write), 32'd0);

        // Reset mid-load
        base = wn;
        pulse_start();
        send(8'hDE, 1'b0); send(8'hAD, 1'b0);
        in_valid = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        check("mid_rst_in_ready", 32'(in_ready), 32'd0);
        check("mid_rst_cpu_hold", 32'(cpu_hold), 32'd0);
        check("mid_rst_wr_data", wr_data, 32'd0);
        check("mid_rst_wr_addr", wr_addr, 32'h00003000);
        check("mid_rst_words", 32'(words_loaded), 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (2) @(posedge clk); #1;
        check("mid_rst_no_write", 32'(wn - base), 32'd0);
        pulse_start();
        send(8'h11, 1'b0); send(8'h22, 1'b0); send(8'h33, 1'b0); send(8'h44, 1'b0);
        in_valid = 1'b0;
        repeat (2) @(posedge clk); #1;
        check("mid_rst_nwrites", 32'(wn - base), 32'd1);
        check("mid_rst_w_data", wd[base], 32'h11223344);
        check("mid_rst_w_idx", wi[base], 32'd0);
        check("mid_rst_words_after", 32'(words_loaded), 32'd1);

        // Overflow on the DEPTH=4 instance
        pulse_start1();
        for (int i = 0; i < 16; i++) send1(8'(8'h10 + i), 1'b0);
        in_data1 = 8'hEE;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done1) break;
        end
        check("ovf_done", 32'(done1), 32'd1);
        check("ovf_full", 32'(full1), 32'd1);
        check("ovf_partial", 32'(partial1), 32'd0);
        check("ovf_words", 32'(words_loaded1), 32'd4);
        repeat (3) @(negedge clk);
        check("ovf_ready_held_low", 32'(in_ready1), 32'd0);
        check("ovf_nwrites", 32'(wn1), 32'd4);
        check("ovf_w0_data", wd1[0], 32'h10111213);
        check("ovf_w3_data", wd1[3], 32'h1C1D1E1F);
        in_valid1 = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
